// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JUMP   = 2'd3
  } pc_sel_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC priority selection: jump over branch over stall over sequential.
module next_pc_mux
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output pc_sel_e     pc_sel
);

  // Wraps modulo 2^32 by construction; the carry out is dropped.
  assign pc_plus4 = pc + PC_STEP;

  always_comb begin
    pc_sel  = SEL_SEQ;
    next_pc = pc_plus4;
    if (jump) begin
      pc_sel  = SEL_JUMP;
      next_pc = word_align(jump_target);
    end else if (branch) begin
      pc_sel  = SEL_BRANCH;
      next_pc = word_align(branch_target);
    end else if (stall) begin
      pc_sel  = SEL_HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID register.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 127
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_addr_o,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        halt_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        addr_err_o,
  output logic        halted_o
);

  // Limit kept 34 bits wide so a 2^30-word memory does not overflow to zero.
  localparam logic [33:0] PC_LIMIT = 34'(IMEM_WORDS) * 34'd4;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  pc_sel_e      pc_sel;
  logic         out_of_range;

  next_pc_mux u_next_pc_mux (
    .pc            (pc_q),
    .stall         (stall_i),
    .branch        (branch_i),
    .branch_target (branch_target_i),
    .jump          (jump_i),
    .jump_target   (jump_target_i),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .pc_sel        (pc_sel)
  );

  assign out_of_range = ({2'b00, pc_q} >= PC_LIMIT);
  assign pc_addr_o    = pc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_o <= '0;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
      addr_err_o   <= 1'b0;
      halted_o     <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: begin
          ifid_valid_o <= 1'b0;
          state_q      <= RUN;
        end
        RUN: begin
          // Halting, for either reason, wins over every redirect and stall.
          if (halt_i || out_of_range) begin
            state_q      <= HALT;
            halted_o     <= 1'b1;
            ifid_instr_o <= '0;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
            if (out_of_range) begin
              addr_err_o <= 1'b1;
            end
          end else begin
            case (pc_sel)
              SEL_JUMP, SEL_BRANCH: begin
                pc_q         <= next_pc;
                ifid_instr_o <= '0;
                ifid_pc4_o   <= '0;
                ifid_valid_o <= 1'b0;
              end
              SEL_HOLD: begin
                pc_q <= pc_q;
              end
              SEL_SEQ: begin
                pc_q         <= next_pc;
                ifid_instr_o <= instr_i;
                ifid_pc4_o   <= pc_plus4;
                ifid_valid_o <= 1'b1;
              end
            endcase
          end
        end
        HALT: begin
          ifid_valid_o <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three configurations checked against a cycle model.
module tb_fetch_unit;

  localparam int unsigned IMEM_A = 127;
  localparam int unsigned IMEM_B = 4;
  localparam int unsigned IMEM_C = 32'h4000_0000;
  localparam logic [31:0] RPC_A  = 32'h0000_0000;
  localparam logic [31:0] RPC_B  = 32'h0000_0000;
  localparam logic [31:0] RPC_C  = 32'hFFFF_FFFC;
  localparam longint unsigned LIMIT_A = 64'(IMEM_A) * 64'd4;
  localparam longint unsigned LIMIT_B = 64'(IMEM_B) * 64'd4;
  localparam longint unsigned LIMIT_C = 64'(IMEM_C) * 64'd4;

  localparam int PH_BOOT = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_HALT = 2;

  typedef struct packed {
    int          phase;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
  } model_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, branch_i, jump_i, halt_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic        idle_bit  = 1'b0;
  logic [31:0] idle_word = 32'd0;

  logic [31:0] pc_a, instr_a, ifid_instr_a, ifid_pc4_a;
  logic        ifid_valid_a, addr_err_a, halted_a;
  logic [31:0] pc_b, instr_b, ifid_instr_b, ifid_pc4_b;
  logic        ifid_valid_b, addr_err_b, halted_b;
  logic [31:0] pc_c, instr_c, ifid_instr_c, ifid_pc4_c;
  logic        ifid_valid_c, addr_err_c, halted_c;

  model_t model_a, model_b, model_c;
  int     n_checks = 0;
  int     n_fail   = 0;

  always #5 clk_i = ~clk_i;

  // Instruction memory: word n holds the value n.
  assign instr_a = pc_a >> 2;
  assign instr_b = pc_b >> 2;
  assign instr_c = pc_c >> 2;

  fetch_unit #(.RESET_PC(RPC_A), .IMEM_WORDS(IMEM_A)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_a), .pc_addr_o(pc_a),
    .stall_i(stall_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i), .halt_i(halt_i),
    .ifid_instr_o(ifid_instr_a), .ifid_pc4_o(ifid_pc4_a), .ifid_valid_o(ifid_valid_a),
    .addr_err_o(addr_err_a), .halted_o(halted_a)
  );

  fetch_unit #(.RESET_PC(RPC_B), .IMEM_WORDS(IMEM_B)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_b), .pc_addr_o(pc_b),
    .stall_i(idle_bit), .branch_i(idle_bit), .branch_target_i(idle_word),
    .jump_i(idle_bit), .jump_target_i(idle_word), .halt_i(idle_bit),
    .ifid_instr_o(ifid_instr_b), .ifid_pc4_o(ifid_pc4_b), .ifid_valid_o(ifid_valid_b),
    .addr_err_o(addr_err_b), .halted_o(halted_b)
  );

  fetch_unit #(.RESET_PC(RPC_C), .IMEM_WORDS(IMEM_C)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_c), .pc_addr_o(pc_c),
    .stall_i(idle_bit), .branch_i(idle_bit), .branch_target_i(idle_word),
    .jump_i(idle_bit), .jump_target_i(idle_word), .halt_i(idle_bit),
    .ifid_instr_o(ifid_instr_c), .ifid_pc4_o(ifid_pc4_c), .ifid_valid_o(ifid_valid_c),
    .addr_err_o(addr_err_c), .halted_o(halted_c)
  );

  function automatic model_t model_reset(input logic [31:0] rpc);
    model_t m;
    m.phase = PH_BOOT;
    m.pc    = rpc;
    m.instr = 32'd0;
    m.pc4   = 32'd0;
    m.valid = 1'b0;
    m.err   = 1'b0;
    return m;
  endfunction

  // One clock of fetch behaviour described by its rules, not by its registers.
  function automatic model_t model_step(input model_t m, input longint unsigned limit,
                                        input logic halt, input logic jump,
                                        input logic [31:0] jt, input logic branch,
                                        input logic [31:0] bt, input logic stall);
    model_t n;
    logic   beyond;
    n      = m;
    beyond = ({32'd0, m.pc} >= limit);
    if (m.phase == PH_BOOT) begin
      n.phase = PH_RUN;
    end else if (m.phase == PH_RUN) begin
      if (halt || beyond) begin
        n.phase = PH_HALT;
        n.err   = m.err | beyond;
        n.valid = 1'b0;
        n.instr = 32'd0;
        n.pc4   = 32'd0;
      end else if (jump || branch) begin
        n.pc    = (jump ? jt : bt) & ~32'd3;
        n.valid = 1'b0;
        n.instr = 32'd0;
        n.pc4   = 32'd0;
      end else if (!stall) begin
        n.instr = m.pc / 4;
        n.pc4   = m.pc + 32'd4;
        n.pc    = m.pc + 32'd4;
        n.valid = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      model_a <= model_reset(RPC_A);
      model_b <= model_reset(RPC_B);
      model_c <= model_reset(RPC_C);
    end else begin
      model_a <= model_step(model_a, LIMIT_A, halt_i, jump_i, jump_target_i,
                            branch_i, branch_target_i, stall_i);
      model_b <= model_step(model_b, LIMIT_B, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      model_c <= model_step(model_c, LIMIT_C, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_group(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] pc4,
                             input logic valid, input logic err, input logic halted,
                             input model_t m);
    checkOutput({tag, "_pc"}, pc, m.pc);
    checkOutput({tag, "_instr"}, instr, m.instr);
    checkOutput({tag, "_pc4"}, pc4, m.pc4);
    checkOutput({tag, "_valid"}, 32'(valid), 32'(m.valid));
    checkOutput({tag, "_err"}, 32'(err), 32'(m.err));
    checkOutput({tag, "_halted"}, 32'(halted), 32'(m.phase == PH_HALT));
  endtask

  task automatic compare_model();
    check_group("model_a", pc_a, ifid_instr_a, ifid_pc4_a, ifid_valid_a, addr_err_a, halted_a, model_a);
    check_group("model_b", pc_b, ifid_instr_b, ifid_pc4_b, ifid_valid_b, addr_err_b, halted_b, model_b);
    check_group("model_c", pc_c, ifid_instr_c, ifid_pc4_c, ifid_valid_c, addr_err_c, halted_c, model_c);
  endtask

  task automatic applyStimulus(input logic halt, input logic jump, input logic [31:0] jt,
                               input logic branch, input logic [31:0] bt, input logic stall);
    halt_i          = halt;
    jump_i          = jump;
    jump_target_i   = jt;
    branch_i        = branch;
    branch_target_i = bt;
    stall_i         = stall;
  endtask

  // Compare on the falling edge, then return just after the next rising edge.
  task automatic step_cycle();
    @(negedge clk_i);
    compare_model();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_ifid_a(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid);
    checkOutput({tag, "_pc"}, pc_a, pc);
    checkOutput({tag, "_instr"}, ifid_instr_a, instr);
    checkOutput({tag, "_pc4"}, ifid_pc4_a, pc4);
    checkOutput({tag, "_valid"}, 32'(ifid_valid_a), 32'(valid));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk_i);
    #2;
    checkOutput("rst_pc_a", pc_a, 32'd0);
    checkOutput("rst_valid_a", 32'(ifid_valid_a), 0);
    checkOutput("rst_pc_c", pc_c, 32'hFFFF_FFFC);
    checkOutput("rst_err_b", 32'(addr_err_b), 0);
    checkOutput("rst_halted_b", 32'(halted_b), 0);

    rst_i = 1'b1;
    step_cycle();
    check_ifid_a("boot", 32'd0, 32'd0, 32'd0, 1'b0);
    step_cycle();
    check_ifid_a("run0", 32'd4, 32'd0, 32'd4, 1'b1);
    checkOutput("wrap_pc_c", pc_c, 32'd0);
    checkOutput("wrap_pc4_c", ifid_pc4_c, 32'd0);
    checkOutput("wrap_instr_c", ifid_instr_c, 32'h3FFF_FFFF);
    step_cycle();
    check_ifid_a("run1", 32'd8, 32'd1, 32'd8, 1'b1);

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      check_ifid_a("stall", 32'd8, 32'd1, 32'd8, 1'b1);
    end
    checkOutput("oor_pc_b", pc_b, 32'd16);
    checkOutput("oor_err_b", 32'(addr_err_b), 1);
    checkOutput("oor_halted_b", 32'(halted_b), 1);
    checkOutput("oor_valid_b", 32'(ifid_valid_b), 0);

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step_cycle();
    check_ifid_a("resume", 32'd12, 32'd2, 32'd12, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'h43, 1'b1, 32'h20, 1'b1);
    step_cycle();
    check_ifid_a("jump", 32'h40, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step_cycle();
    check_ifid_a("after_jump", 32'h44, 32'h10, 32'h44, 1'b1);

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h102, 1'b1);
    step_cycle();
    check_ifid_a("branch", 32'h100, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step_cycle();
    check_ifid_a("after_branch", 32'h104, 32'h40, 32'h104, 1'b1);
    checkOutput("oor_hold_pc_b", pc_b, 32'd16);

    rst_i = 1'b0;
    #1;
    checkOutput("midrst_pc_a", pc_a, 32'd0);
    checkOutput("midrst_valid_a", 32'(ifid_valid_a), 0);
    checkOutput("midrst_pc_b", pc_b, 32'd0);
    checkOutput("midrst_err_b", 32'(addr_err_b), 0);
    checkOutput("midrst_halted_b", 32'(halted_b), 0);
    step_cycle();
    step_cycle();

    rst_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    step_cycle();
    check_ifid_a("boot_ignore", 32'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("boot_ignore_halted_a", 32'(halted_a), 0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step_cycle();
    check_ifid_a("seg2_run", 32'd4, 32'd0, 32'd4, 1'b1);

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h80, 1'b0);
    step_cycle();
    check_ifid_a("halt", 32'd4, 32'd0, 32'd0, 1'b0);
    checkOutput("halt_halted_a", 32'(halted_a), 1);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 32'h80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      checkOutput("halt_hold_pc_a", pc_a, 32'd4);
      checkOutput("halt_hold_halted_a", 32'(halted_a), 1);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

    rst_i = 1'b0;
    #1;
    checkOutput("halt_rst_pc_a", pc_a, 32'd0);
    checkOutput("halt_rst_halted_a", 32'(halted_a), 0);
    step_cycle();
    rst_i = 1'b1;
    step_cycle();
    check_ifid_a("reboot", 32'd0, 32'd0, 32'd0, 1'b0);
    step_cycle();
    check_ifid_a("rerun", 32'd4, 32'd0, 32'd4, 1'b1);
    step_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
